// File: rtl/seq_shift_add_multiplier.sv
// Iterative radix-2 shift-and-add multiplier with signed/unsigned mode and
// valid/ready handshakes; one WIDTH+1-bit adder, fixed WIDTH-cycle latency.
module seq_shift_add_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 signed_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  state_t               state_next;

  logic [WIDTH-1:0]     mcand;
  logic [WIDTH-1:0]     mult;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   acc_next;
  logic [2*WIDTH-1:0]   result;
  logic [WIDTH:0]       sum;
  logic [CW-1:0]        count;
  logic                 neg;
  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;
  logic                 accept;
  logic                 last;

  assign in_ready  = (state == IDLE) & ~rst;
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid & in_ready;
  assign last      = (state == CALC) && (count == CW'(1));

  // Signed operands are reduced to magnitudes; the most negative value maps
  // onto 2^(WIDTH-1), which is still representable as an unsigned WIDTH-bit value.
  always_comb begin
    a_mag = a;
    b_mag = b;
    if (signed_mode && a[WIDTH-1]) a_mag = ~a + WIDTH'(1);
    if (signed_mode && b[WIDTH-1]) b_mag = ~b + WIDTH'(1);
  end

  // One iteration: add into the upper half keeping the carry, then shift the
  // carry back into the accumulator.
  always_comb begin
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (mult[0] ? mcand : '0)};
    acc_next = (2*WIDTH)'({sum, acc[WIDTH-1:0]} >> 1);
    result   = neg ? (~acc_next + (2*WIDTH)'(1)) : acc_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept)    state_next = CALC;
      CALC:    if (last)      state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // product is only written on the final iteration so it holds through DONE
  // and keeps its last value once back in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand   <= '0;
      mult    <= '0;
      acc     <= '0;
      count   <= '0;
      neg     <= 1'b0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            mcand <= a_mag;
            mult  <= b_mag;
            acc   <= '0;
            count <= CW'(WIDTH);
            neg   <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
          end
        end
        CALC: begin
          acc   <= acc_next;
          mult  <= mult >> 1;
          count <= count - CW'(1);
          if (last) product <= result;
        end
        default: ;
      endcase
    end
  end

endmodule
